// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with registered winner decoded to a one-hot grant.
// A grant is held until its owner drops the request, en falls, or MAX_HOLD expires.
module rr_decoder_arbiter #(
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [1:0]        id_nxt;
    logic [3:0]        grant_nxt;
    logic              valid_nxt;
    logic              timeout_nxt;
    logic [1:0]        winner;
    logic [1:0]        cand;
    logic              found;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set request wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        id_nxt      = gnt_id;
        grant_nxt   = '0;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_nxt = GRANT;
                    id_nxt    = winner;
                    hold_nxt  = '0;
                    grant_nxt = 4'b0001 << winner;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (!req[gnt_id]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_id + 2'd1;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_id + 2'd1;
                    timeout_nxt = 1'b1;
                end else begin
                    // Saturate so an unlimited hold never wraps the counter.
                    if (hold_cnt != '1) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                    grant_nxt = 4'b0001 << gnt_id;
                    valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_id    <= '0;
            grant     <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_id    <= id_nxt;
            grant     <= grant_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: expected grant/timeout pushed per step,
// popped and compared one cycle later; a second instance covers MAX_HOLD=0.
module tb_rr_decoder_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant,  grant0;
    logic [1:0] gnt_id, gnt_id0;
    logic       gnt_valid, gnt_valid0;
    logic       timeout, timeout0;

    int ncomp = 0;
    int nfail = 0;
    logic sel0 = 1'b0;

    typedef struct {
        logic [3:0] g;
        logic       to;
        logic       alt;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    rr_decoder_arbiter #(.HOLD_W(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(grant), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_decoder_arbiter #(.HOLD_W(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(grant0), .gnt_id(gnt_id0), .gnt_valid(gnt_valid0), .timeout(timeout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic expect_out(input logic [3:0] eg, input logic et, input string tag);
        exp_t e;
        e.g   = eg;
        e.to  = et;
        e.alt = sel0;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [3:0] g;
        logic [1:0] id;
        logic       v, t;
        if (sbq.size() == 0) begin
            ncomp++;
            nfail++;
            $error("FAIL sb_empty: got no expectation, required one");
            return;
        end
        e = sbq.pop_front();
        if (e.alt) begin
            g = grant0; id = gnt_id0; v = gnt_valid0; t = timeout0;
        end else begin
            g = grant;  id = gnt_id;  v = gnt_valid;  t = timeout;
        end
        ncomp++;
        assert (g === e.g) else begin
            nfail++;
            $error("FAIL %s grant: got %b required %b", e.tag, g, e.g);
        end
        ncomp++;
        assert (v === (|e.g)) else begin
            nfail++;
            $error("FAIL %s gnt_valid: got %b required %b", e.tag, v, |e.g);
        end
        ncomp++;
        assert (t === e.to) else begin
            nfail++;
            $error("FAIL %s timeout: got %b required %b", e.tag, t, e.to);
        end
        if (e.g != 4'b0000) begin
            ncomp++;
            assert (id === oh_idx(e.g)) else begin
                nfail++;
                $error("FAIL %s gnt_id: got %0d required %0d", e.tag, id, oh_idx(e.g));
            end
        end
    endtask

    // Drive inputs after a falling edge; outputs are checked 1ns after the next rising edge.
    task automatic step(input logic e, input logic [3:0] r, input logic [3:0] eg,
                        input logic et, input string tag);
        en  = e;
        req = r;
        expect_out(eg, et, tag);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        en    = 1'b1;
        req   = r;
        #3;
        expect_out(4'b0000, 1'b0, "reset");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'hF;
        @(negedge clk);

        // T1: reset with all requests pending, first grant goes to requester 0
        do_reset(4'hF);
        step(1'b1, 4'hF, 4'b0001, 1'b0, "t1_first");
        step(1'b1, 4'h0, 4'b0000, 1'b0, "t1_rel");
        step(1'b1, 4'h0, 4'b0000, 1'b0, "t1_idle");

        // T2: hold while requesting, release moves ptr past the owner
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 4'b0100, 1'b0, $sformatf("t2_hold%0d", i));
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t2_rel");
        step(1'b1, 4'b1111, 4'b1000, 1'b0, "t2_ptr3");
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t2_rel2");
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t2_idle");

        // T3: all requesting, each grant lasts 8 cycles then a timeout gap
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 4'b1111, 4'(1 << (k % 4)), 1'b0, $sformatf("t3_g%0d_c%0d", k, c));
            end
            step(1'b1, 4'b1111, 4'b0000, 1'b1, $sformatf("t3_to%0d", k));
        end
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t3_idle");

        // T4: en drop releases without timeout and leaves ptr at 1
        step(1'b1, 4'b0010, 4'b0010, 1'b0, "t4_gnt");
        step(1'b1, 4'b0010, 4'b0010, 1'b0, "t4_hold");
        step(1'b0, 4'b0010, 4'b0000, 1'b0, "t4_endrop");
        step(1'b0, 4'b1111, 4'b0000, 1'b0, "t4_blocked");
        step(1'b1, 4'b1111, 4'b0010, 1'b0, "t4_regnt");
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t4_rel");

        // T6: reset mid-grant is immediate and clears ptr
        step(1'b1, 4'b1000, 4'b1000, 1'b0, "t6_gnt");
        step(1'b1, 4'b1000, 4'b1000, 1'b0, "t6_hold");
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(4'b0000, 1'b0, "t6_async");
        check_out();
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b1001, 4'b0001, 1'b0, "t6_ptr0");
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t6_rel");

        // T5: unlimited hold on the MAX_HOLD=0 instance
        sel0 = 1'b1;
        do_reset(4'b0001);
        for (int c = 0; c < 40; c++) step(1'b1, 4'b0001, 4'b0001, 1'b0, $sformatf("t5_c%0d", c));
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "t5_rel");
        step(1'b1, 4'b0001, 4'b0010 >> 1, 1'b0, "t5_regnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
